// File: rtl/last_stage_dispatch.sv
// last_stage_dispatch: final-stage PHV dispatcher. Holds one PHV and
// delivers it to every output queue selected by its queue-mask field,
// tracking per-port completion, with per-port delivery and drop counters.
module last_stage_dispatch #(
    parameter int PHV_LEN       = 2304,
    parameter int NUM_PORTS     = 4,
    parameter int PORT_MASK_OFF = 141,
    parameter int LOCKSTEP      = 0,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                           axis_clk,
    input  logic                           areset,
    input  logic [PHV_LEN-1:0]             phv_in,
    input  logic                           phv_in_valid,
    output logic                           phv_in_ready,
    output logic [PHV_LEN-1:0]             phv_out,
    output logic [NUM_PORTS-1:0]           phv_out_valid,
    input  logic [NUM_PORTS-1:0]           phv_fifo_ready,
    input  logic                           cnt_clr,
    output logic [NUM_PORTS*CNT_WIDTH-1:0] port_pkt_cnt,
    output logic [CNT_WIDTH-1:0]           drop_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [PHV_LEN-1:0]   r_phv;
    logic [NUM_PORTS-1:0] r_pend;
    logic [CNT_WIDTH-1:0] r_port_cnt [NUM_PORTS];
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    logic [NUM_PORTS-1:0] w_mask;
    logic [NUM_PORTS-1:0] w_valid;
    logic [NUM_PORTS-1:0] w_fire;
    logic [NUM_PORTS-1:0] w_pend_left;
    logic                 w_all_rdy;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_drop;

    // Mask bits beyond NUM_PORTS are simply never looked at.
    assign w_mask    = phv_in[PORT_MASK_OFF +: NUM_PORTS];
    assign w_all_rdy = ((r_pend & ~phv_fifo_ready) == '0);

    // In lockstep mode valid is withheld until every pending port can take
    // the PHV, so all of them complete together.
    assign w_valid = (LOCKSTEP != 0) ? (r_pend & {NUM_PORTS{w_all_rdy}})
                                     : r_pend;
    assign w_fire  = w_valid & phv_fifo_ready;

    // In lockstep mode fire equals pend on all_rdy and is zero otherwise,
    // so the same clear expression serves both modes.
    assign w_pend_left = r_pend & ~w_fire;

    assign phv_in_ready = (w_pend_left == '0);
    assign w_accept     = phv_in_valid && phv_in_ready;
    assign w_load       = w_accept && (w_mask != '0);
    assign w_drop       = w_accept && (w_mask == '0);

    assign phv_out       = r_phv;
    assign phv_out_valid = w_valid;

    // Holding register and pending mask; a new load overrides the clear.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            r_phv  <= '0;
            r_pend <= '0;
        end else if (w_load) begin
            r_phv  <= phv_in;
            r_pend <= w_mask;
        end else begin
            r_pend <= w_pend_left;
        end
    end

    // Saturating statistics; a clear wins over an increment in the same cycle.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_PORTS; i++) r_port_cnt[i] <= '0;
            r_drop_cnt <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < NUM_PORTS; i++) r_port_cnt[i] <= '0;
            r_drop_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_fire[i] && (r_port_cnt[i] != CNT_MAX))
                    r_port_cnt[i] <= r_port_cnt[i] + CNT_ONE;
            end
            if (w_drop && (r_drop_cnt != CNT_MAX))
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
            assign port_pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_port_cnt[g];
        end
    endgenerate

    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_last_stage_dispatch.sv
// Directed bench for last_stage_dispatch: table of per-cycle vectors for the
// independent-completion dispatcher, then hand-written lockstep, streaming,
// reset and counter-saturation sequences.
module tb_last_stage_dispatch;

    localparam int PL  = 64;
    localparam int NP  = 4;
    localparam int OFF = 20;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Inputs shared by u_a (32-bit counters) and u_c (4-bit counters)
    logic [PL-1:0]    a_phv_in;
    logic             a_vld;
    logic [NP-1:0]    a_rdy;
    logic             a_clr;
    logic             a_ir,  c_ir;
    logic [PL-1:0]    a_out, c_out;
    logic [NP-1:0]    a_ov,  c_ov;
    logic [NP*32-1:0] a_cnt;
    logic [31:0]      a_drop;
    logic [NP*4-1:0]  c_cnt;
    logic [3:0]       c_drop;

    // Lockstep instance
    logic [PL-1:0]    b_phv_in;
    logic             b_vld;
    logic [NP-1:0]    b_rdy;
    logic             b_ir;
    logic [PL-1:0]    b_out;
    logic [NP-1:0]    b_ov;
    logic [NP*32-1:0] b_cnt;
    logic [31:0]      b_drop;

    last_stage_dispatch #(.PHV_LEN(PL), .NUM_PORTS(NP), .PORT_MASK_OFF(OFF),
                          .LOCKSTEP(0), .CNT_WIDTH(32)) u_a (
        .axis_clk(clk), .areset(rst), .phv_in(a_phv_in), .phv_in_valid(a_vld),
        .phv_in_ready(a_ir), .phv_out(a_out), .phv_out_valid(a_ov),
        .phv_fifo_ready(a_rdy), .cnt_clr(a_clr), .port_pkt_cnt(a_cnt),
        .drop_cnt(a_drop));

    last_stage_dispatch #(.PHV_LEN(PL), .NUM_PORTS(NP), .PORT_MASK_OFF(OFF),
                          .LOCKSTEP(1), .CNT_WIDTH(32)) u_b (
        .axis_clk(clk), .areset(rst), .phv_in(b_phv_in), .phv_in_valid(b_vld),
        .phv_in_ready(b_ir), .phv_out(b_out), .phv_out_valid(b_ov),
        .phv_fifo_ready(b_rdy), .cnt_clr(a_clr), .port_pkt_cnt(b_cnt),
        .drop_cnt(b_drop));

    last_stage_dispatch #(.PHV_LEN(PL), .NUM_PORTS(NP), .PORT_MASK_OFF(OFF),
                          .LOCKSTEP(0), .CNT_WIDTH(4)) u_c (
        .axis_clk(clk), .areset(rst), .phv_in(a_phv_in), .phv_in_valid(a_vld),
        .phv_in_ready(c_ir), .phv_out(c_out), .phv_out_valid(c_ov),
        .phv_fifo_ready(a_rdy), .cnt_clr(a_clr), .port_pkt_cnt(c_cnt),
        .drop_cnt(c_drop));

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic          vld;
        logic [3:0]    mask;
        logic [31:0]   tag;
        logic [3:0]    rdy;
        logic          exp_ir;
        logic [3:0]    exp_ov;
        logic [PL-1:0] exp_phv;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [PL-1:0] mk(input logic [3:0] m, input logic [31:0] tag);
        logic [PL-1:0] p;
        p = '0;
        p[PL-1:32] = tag;
        p[OFF +: NP] = m;
        p[OFF+NP]    = 1'b1;  // a set bit above the mask field must be ignored
        return p;
    endfunction

    task automatic chk(input string name, input logic [PL-1:0] act, input logic [PL-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven
    // and outputs settle before sampling, well clear of either edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] pcnt(input logic [NP*32-1:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    int delivered;

    initial begin
        rst = 1'b1; a_phv_in = '0; a_vld = 1'b0; a_rdy = '0; a_clr = 1'b0;
        b_phv_in = '0; b_vld = 1'b0; b_rdy = '0;
        tick(); tick();
        rst = 1'b0;
        #1;

        chk("reset_in_ready", {63'd0, a_ir}, 64'd1);
        chk("reset_out_valid", {60'd0, a_ov}, 64'd0);
        chk("reset_phv_out", a_out, '0);
        chk("reset_cnt", a_cnt[63:0] | a_cnt[127:64], 64'd0);

        // vld mask tag rdy | exp in_ready, exp out_valid, exp phv_out
        tbl[0]  = '{1'b1, 4'b0100, 32'hA1, 4'b1111, 1'b1, 4'b0000, '0};
        tbl[1]  = '{1'b0, 4'b0000, 32'h00, 4'b1111, 1'b1, 4'b0100, mk(4'b0100, 32'hA1)};
        tbl[2]  = '{1'b0, 4'b0000, 32'h00, 4'b1111, 1'b1, 4'b0000, mk(4'b0100, 32'hA1)};
        tbl[3]  = '{1'b1, 4'b1011, 32'hB2, 4'b0000, 1'b1, 4'b0000, mk(4'b0100, 32'hA1)};
        tbl[4]  = '{1'b0, 4'b0000, 32'h00, 4'b0001, 1'b0, 4'b1011, mk(4'b1011, 32'hB2)};
        tbl[5]  = '{1'b0, 4'b0000, 32'h00, 4'b0000, 1'b0, 4'b1010, mk(4'b1011, 32'hB2)};
        tbl[6]  = '{1'b0, 4'b0000, 32'h00, 4'b0010, 1'b0, 4'b1010, mk(4'b1011, 32'hB2)};
        tbl[7]  = '{1'b0, 4'b0000, 32'h00, 4'b0000, 1'b0, 4'b1000, mk(4'b1011, 32'hB2)};
        tbl[8]  = '{1'b1, 4'b0001, 32'hC3, 4'b1000, 1'b1, 4'b1000, mk(4'b1011, 32'hB2)};
        tbl[9]  = '{1'b1, 4'b0000, 32'hD4, 4'b1111, 1'b1, 4'b0001, mk(4'b0001, 32'hC3)};
        tbl[10] = '{1'b1, 4'b0001, 32'hE5, 4'b1111, 1'b1, 4'b0000, mk(4'b0001, 32'hC3)};
        tbl[11] = '{1'b0, 4'b0000, 32'h00, 4'b1111, 1'b1, 4'b0001, mk(4'b0001, 32'hE5)};
        tbl[12] = '{1'b0, 4'b0000, 32'h00, 4'b1111, 1'b1, 4'b0000, mk(4'b0001, 32'hE5)};

        for (int k = 0; k < 13; k++) begin
            tick();
            a_vld    = tbl[k].vld;
            a_phv_in = mk(tbl[k].mask, tbl[k].tag);
            a_rdy    = tbl[k].rdy;
            #1;
            chk($sformatf("vec%0d_in_ready", k), {63'd0, a_ir}, {63'd0, tbl[k].exp_ir});
            chk($sformatf("vec%0d_out_valid", k), {60'd0, a_ov}, {60'd0, tbl[k].exp_ov});
            chk($sformatf("vec%0d_phv_out", k), a_out, tbl[k].exp_phv);
        end
        tick();
        chk("tbl_cnt_p0", {32'd0, pcnt(a_cnt, 0)}, 64'd3);
        chk("tbl_cnt_p1", {32'd0, pcnt(a_cnt, 1)}, 64'd1);
        chk("tbl_cnt_p2", {32'd0, pcnt(a_cnt, 2)}, 64'd1);
        chk("tbl_cnt_p3", {32'd0, pcnt(a_cnt, 3)}, 64'd1);
        chk("tbl_drop", {32'd0, a_drop}, 64'd1);
        chk("tbl_c_drop", {60'd0, c_drop}, 64'd1);

        // Lockstep: mask 0011, port 1 stalls three cycles
        b_vld = 1'b1; b_phv_in = mk(4'b0011, 32'h5A); b_rdy = 4'b0001;
        tick();
        b_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("lock_stall%0d_valid", k), {60'd0, b_ov}, 64'd0);
            chk($sformatf("lock_stall%0d_in_ready", k), {63'd0, b_ir}, 64'd0);
            tick();
        end
        b_rdy = 4'b0011;
        #1;
        chk("lock_release_valid", {60'd0, b_ov}, 64'b0011);
        chk("lock_release_in_ready", {63'd0, b_ir}, 64'd1);
        chk("lock_phv_out", b_out, mk(4'b0011, 32'h5A));
        tick();
        b_rdy = 4'b0000;
        #1;
        chk("lock_after_valid", {60'd0, b_ov}, 64'd0);
        chk("lock_after_in_ready", {63'd0, b_ir}, 64'd1);
        chk("lock_cnt", {pcnt(b_cnt, 1), pcnt(b_cnt, 0)}, {32'd1, 32'd1});
        chk("lock_drop", {32'd0, b_drop}, 64'd0);

        // Streaming: 100 back-to-back unicast PHVs to rotating ports
        delivered = 0;
        a_rdy = 4'b1111;
        for (int cyc = 0; cyc <= 100; cyc++) begin
            if (cyc < 100) begin
                a_vld = 1'b1;
                a_phv_in = mk(4'(1 << (cyc % 4)), 32'(cyc + 256));
            end else begin
                a_vld = 1'b0;
            end
            #1;
            if (a_ir !== 1'b1) begin
                n_chk++; n_err++;
                $display("FAIL stream_in_ready cyc%0d: got %b expected 1", cyc, a_ir);
            end
            delivered += $countones(a_ov & a_rdy);
            if (cyc > 0) begin
                n_chk++;
                if (a_ov !== 4'(1 << ((cyc - 1) % 4)) ||
                    a_out !== mk(4'(1 << ((cyc - 1) % 4)), 32'(cyc + 255))) begin
                    n_err++;
                    $display("FAIL stream_out cyc%0d: got valid %b data %h", cyc, a_ov, a_out);
                end
            end
            tick();
        end
        chk("stream_delivered", 64'(delivered), 64'd100);
        chk("stream_cnt_p0", {32'd0, pcnt(a_cnt, 0)}, 64'd28);
        chk("stream_cnt_p3", {32'd0, pcnt(a_cnt, 3)}, 64'd26);

        // Reset in the middle of a multicast that cannot complete
        a_vld = 1'b1; a_phv_in = mk(4'b1111, 32'h77); a_rdy = 4'b0000;
        tick();
        a_vld = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {60'd0, a_ov}, 64'd0);
        chk("rst_phv_out", a_out, '0);
        chk("rst_in_ready", {63'd0, a_ir}, 64'd1);
        chk("rst_cnt", {a_cnt[63:0] | a_cnt[127:64]} | {32'd0, a_drop}, 64'd0);
        tick();
        rst = 1'b0;
        a_rdy = 4'b1111;
        tick();
        #1;
        chk("rst_no_replay", {60'd0, a_ov}, 64'd0);
        chk("rst_no_replay_cnt", {32'd0, pcnt(a_cnt, 0)}, 64'd0);

        // Saturation: 20 fires to port 0
        for (int k = 0; k < 20; k++) begin
            a_vld = 1'b1; a_phv_in = mk(4'b0001, 32'(k));
            tick();
        end
        a_vld = 1'b0;
        tick();
        chk("sat_c_p0", {60'd0, c_cnt[3:0]}, 64'd15);
        chk("sat_a_p0", {32'd0, pcnt(a_cnt, 0)}, 64'd20);
        chk("sat_c_in_ready", {63'd0, c_ir}, 64'd1);
        chk("sat_c_phv_out", c_out, mk(4'b0001, 32'd19));
        chk("sat_c_valid", {60'd0, c_ov}, 64'd0);

        // Clear coincides with a fire
        a_vld = 1'b1; a_phv_in = mk(4'b0001, 32'h99);
        tick();
        a_vld = 1'b0; a_clr = 1'b1;
        #1;
        chk("clr_fire_valid", {60'd0, c_ov}, 64'b0001);
        tick();
        a_clr = 1'b0;
        #1;
        chk("clr_c_p0", {60'd0, c_cnt[3:0]}, 64'd0);
        chk("clr_a_p0", {32'd0, pcnt(a_cnt, 0)}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/last_stage_dispatch.md
# last_stage_dispatch

Parametrised output dispatcher for the final RMT stage. It takes finished PHVs from the action engine and delivers each one to the output-queue PHV FIFOs selected by the queue-mask field inside the PHV. The mask supports unicast and multicast. Backpressure is handled per port, and per-port and drop statistics are kept. It sits between `action_engine` and the per-queue PHV FIFOs. It replaces the fixed 4-way fan-out, which gated on all ready signals being high at once.

## Interface
Parameters:
- `PHV_LEN`, 2304: PHV width in bits.
- `NUM_PORTS`, 4: number of output queues; range 1–16.
- `PORT_MASK_OFF`, 141: LSB of the queue-mask field `phv[PORT_MASK_OFF +: NUM_PORTS]`.
- `LOCKSTEP`, 0: 0 = independent per-port completion; 1 = all selected ports must accept in the same cycle.
- `CNT_WIDTH`, 32: width of each statistics counter.

Ports:
- `axis_clk` in 1: clock.
- `areset` in 1: reset. Asynchronous and active-high.
- `phv_in` in PHV_LEN: PHV from the action engine.
- `phv_in_valid` in 1: input valid.
- `phv_in_ready` out 1: input ready. Transfer occurs when valid && ready.
- `phv_out` out PHV_LEN: held PHV, shared by all ports.
- `phv_out_valid` out NUM_PORTS: per-port valid.
- `phv_fifo_ready` in NUM_PORTS: per-port ready.
- `cnt_clr` in 1: synchronous clear of all counters.
- `port_pkt_cnt` out NUM_PORTS*CNT_WIDTH: per-port delivered-PHV counters. Port i is at `[i*CNT_WIDTH +: CNT_WIDTH]`.
- `drop_cnt` out CNT_WIDTH: count of PHVs received with a zero mask.

## Operation
- State:
  - holding register `phv_r` (PHV_LEN);
  - pending mask `pend` (NUM_PORTS).
  - The block is IDLE when `pend == 0` and BUSY otherwise.
- Per-port transfer: `fire[i] = phv_out_valid[i] && phv_fifo_ready[i]`.
- `LOCKSTEP=0`:
  - `phv_out_valid[i] = pend[i]`. Valid does not depend on ready.
  - Each cycle, `pend <= pend & ~fire`.
- `LOCKSTEP=1`:
  - `all_rdy = ((pend & ~phv_fifo_ready) == 0)`.
  - `phv_out_valid[i] = pend[i] && all_rdy`.
  - On `all_rdy`, `pend` clears entirely.
- `phv_in_ready = ((pend & ~fire) == 0)`. Input is accepted in IDLE, or in the cycle the last pending port(s) fire.
- On accept with mask `m = phv_in[PORT_MASK_OFF +: NUM_PORTS]`:
  - if `m != 0`: `phv_r <= phv_in`, `pend <= m`;
  - if `m == 0`: PHV is dropped, `drop_cnt` increments, `pend` stays 0 (after any fires that cycle), `phv_r` is unchanged.
- Mask bits above NUM_PORTS are ignored.
- `phv_out = phv_r` at all times.
- Counters:
  - `port_pkt_cnt[i]` increments on each `fire[i]`.
  - All counters saturate at all-ones.
  - `cnt_clr` zeroes all counters and takes priority over an increment in the same cycle.
- Reset values: `pend = 0`, `phv_r = 0`, all counters 0. Hence `phv_out_valid = 0`, `phv_out = 0`, `phv_in_ready = 1`.
- Reset mid-operation: the held PHV is discarded and not delivered. Counters clear. No partial-multicast state survives.

## Timing
- Latency: accept at cycle N gives `phv_out_valid` from cycle N+1.
- Throughput: one PHV per cycle when all selected ports are ready every cycle.
- The load of a new PHV overrides clearing of `pend` in the same cycle.
- Multicast, `LOCKSTEP=0`:
  - Ports finish in any order.
  - A port that has fired deasserts valid the next cycle and receives no duplicate.
  - The next PHV is accepted in the cycle the last remaining port fires.
- `phv_in_ready` is combinational from `phv_fifo_ready` and `pend`. No combinational path exists from `phv_in_valid` to any output.
- `phv_out_valid` is combinational from `phv_fifo_ready` only when `LOCKSTEP=1`.
- A zero-mask drop consumes one input cycle and produces no output cycle.

## Test plan
- Unicast, `NUM_PORTS=4`, `LOCKSTEP=0`: PHV with mask `4'b0100`, all ready -> `phv_out_valid = 4'b0100` one cycle after accept, for one cycle; `port_pkt_cnt[2] = 1`.
- Multicast staggered, `LOCKSTEP=0`: mask `4'b1011`, ports 0/1/3 ready at cycles +1/+3/+5 -> each valid drops after its own fire; `phv_in_ready` is low until cycle +5 and high at +5; counters 0, 1 and 3 each read 1.
- Lockstep, `LOCKSTEP=1`: mask `4'b0011`, port 1 not ready for 3 cycles -> `phv_out_valid = 0` for those 3 cycles; both bits assert in the cycle port 1 becomes ready; `pend` clears.
- Zero-mask drop: send mask 0, then mask `4'b0001` back-to-back -> `drop_cnt = 1`; only the second PHV appears, with its data intact.
- Streaming plus reset: 100 back-to-back unicast PHVs to rotating ports, all ready -> 100 delivered in 101 cycles; `areset` pulse in the middle -> outputs are 0 immediately and `phv_in_ready = 1`.
- Counters, `CNT_WIDTH=4`: 20 fires to port 0 -> count holds at 15. Asserting `cnt_clr` in a cycle with a fire -> count reads 0 the next cycle.
